// File: rtl/traffic_pkg.sv
// Shared codes and types for the traffic lamp sequencer.
// Command, lamp and approach encodings plus the sequencer state enum.
package traffic_pkg;

  localparam logic [1:0] CMD_GO   = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_AMB = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] IDX_E = 2'd0;
  localparam logic [1:0] IDX_W = 2'd1;
  localparam logic [1:0] IDX_N = 2'd2;
  localparam logic [1:0] IDX_S = 2'd3;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    AMBER,
    FAULT
  } state_t;

endpackage

// File: rtl/approach_req_decode.sv
// Combinational decode of the four approach commands.
// Flags a single legal go request, an all-stop pattern, or an illegal mix.
module approach_req_decode
  import traffic_pkg::*;
(
  input  logic [1:0] i_cmd_e,
  input  logic [1:0] i_cmd_w,
  input  logic [1:0] i_cmd_n,
  input  logic [1:0] i_cmd_s,
  output logic       o_valid_req,
  output logic       o_no_req,
  output logic       o_illegal,
  output logic [1:0] o_req_idx
);

  logic [3:0] w_go;
  logic [3:0] w_stop;

  assign w_go = {
    i_cmd_s == CMD_GO,
    i_cmd_n == CMD_GO,
    i_cmd_w == CMD_GO,
    i_cmd_e == CMD_GO
  };

  assign w_stop = {
    i_cmd_s == CMD_STOP,
    i_cmd_n == CMD_STOP,
    i_cmd_w == CMD_STOP,
    i_cmd_e == CMD_STOP
  };

  always_comb begin
    o_valid_req = 1'b0;
    o_req_idx   = IDX_E;
    unique case (1'b1)
      (w_go == 4'b0001 && w_stop == 4'b1110): begin
        o_valid_req = 1'b1;
        o_req_idx   = IDX_E;
      end
      (w_go == 4'b0010 && w_stop == 4'b1101): begin
        o_valid_req = 1'b1;
        o_req_idx   = IDX_W;
      end
      (w_go == 4'b0100 && w_stop == 4'b1011): begin
        o_valid_req = 1'b1;
        o_req_idx   = IDX_N;
      end
      (w_go == 4'b1000 && w_stop == 4'b0111): begin
        o_valid_req = 1'b1;
        o_req_idx   = IDX_S;
      end
      default: ;
    endcase
  end

  assign o_no_req  = (w_stop == 4'b1111);
  assign o_illegal = !(o_valid_req || o_no_req);

endmodule

// File: rtl/phase_lamp_sequencer.sv
// Lamp sequencer: timed amber and all-red clearance between greens.
// Illegal command patterns that persist latch a flashing-amber fault.
module phase_lamp_sequencer
  import traffic_pkg::*;
#(
  parameter int AMBER_TICKS  = 3,
  parameter int CLEAR_TICKS  = 2,
  parameter int CNT_W        = 4,
  parameter int FAULT_FILTER = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] cmd_e,
  input  logic [1:0] cmd_w,
  input  logic [1:0] cmd_n,
  input  logic [1:0] cmd_s,
  output logic [2:0] lamp_e,
  output logic [2:0] lamp_w,
  output logic [2:0] lamp_n,
  output logic [2:0] lamp_s,
  output logic [1:0] active_idx,
  output logic       fault
);

  localparam int FLT_W = $clog2(FAULT_FILTER + 1);

  localparam logic [CNT_W-1:0] AMB_LD = CNT_W'(AMBER_TICKS);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLEAR_TICKS);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
  localparam logic [FLT_W-1:0] FLT_MX = FLT_W'(FAULT_FILTER);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_le1;

  logic [FLT_W-1:0] r_filt;
  logic [FLT_W-1:0] w_filt_inc;
  logic [FLT_W-1:0] w_filt_nxt;
  logic             w_fault_hit;

  logic [1:0]       r_active;
  logic [1:0]       w_active_nxt;
  logic             r_flash;
  logic             w_flash_nxt;
  logic             r_fault;

  logic [3:0][2:0]  r_lamps;
  logic [3:0][2:0]  w_lamps_nxt;

  logic             w_valid;
  logic             w_none;
  logic             w_illegal;
  logic [1:0]       w_req_idx;

  approach_req_decode u_dec (
    .i_cmd_e     (cmd_e),
    .i_cmd_w     (cmd_w),
    .i_cmd_n     (cmd_n),
    .i_cmd_s     (cmd_s),
    .o_valid_req (w_valid),
    .o_no_req    (w_none),
    .o_illegal   (w_illegal),
    .o_req_idx   (w_req_idx)
  );

  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CNT_1;
  assign w_cnt_le1 = (r_cnt <= CNT_1);

  assign w_filt_inc = r_filt + 1'b1;
  assign w_filt_nxt = !w_illegal       ? '0 :
                      (r_filt == FLT_MX) ? r_filt : w_filt_inc;
  assign w_fault_hit = w_illegal && (w_filt_inc >= FLT_MX);

  // Fault entry ignores tick and overrides every other transition.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_flash_nxt  = r_flash;
    if (w_fault_hit && r_state != FAULT) begin
      w_state_nxt = FAULT;
      w_flash_nxt = 1'b1;
    end else if (tick) begin
      unique case (r_state)
        ALL_RED: begin
          if (w_cnt_le1 && w_valid) begin
            w_state_nxt  = GREEN;
            w_active_nxt = w_req_idx;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        GREEN: begin
          if ((w_valid && w_req_idx != r_active) || w_none) begin
            w_state_nxt = AMBER;
            w_cnt_nxt   = AMB_LD;
          end
        end
        AMBER: begin
          if (w_cnt_le1) begin
            w_state_nxt = ALL_RED;
            w_cnt_nxt   = CLR_LD;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        FAULT: w_flash_nxt = ~r_flash;
        default: ;
      endcase
    end
  end

  // Lamps follow the next state so they update on the same edge.
  always_comb begin
    w_lamps_nxt = {4{LAMP_RED}};
    unique case (w_state_nxt)
      GREEN:   w_lamps_nxt[w_active_nxt] = LAMP_GRN;
      AMBER:   w_lamps_nxt[w_active_nxt] = LAMP_AMB;
      FAULT:   w_lamps_nxt = {4{w_flash_nxt ? LAMP_AMB : LAMP_OFF}};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ALL_RED;
      r_cnt    <= CLR_LD;
      r_filt   <= '0;
      r_active <= IDX_E;
      r_flash  <= 1'b0;
      r_fault  <= 1'b0;
      r_lamps  <= {4{LAMP_RED}};
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_filt   <= w_filt_nxt;
      r_active <= w_active_nxt;
      r_flash  <= w_flash_nxt;
      r_fault  <= (w_state_nxt == FAULT);
      r_lamps  <= w_lamps_nxt;
    end
  end

  assign lamp_e     = r_lamps[IDX_E];
  assign lamp_w     = r_lamps[IDX_W];
  assign lamp_n     = r_lamps[IDX_N];
  assign lamp_s     = r_lamps[IDX_S];
  assign active_idx = r_active;
  assign fault      = r_fault;

endmodule

// File: tb/tb_phase_lamp_sequencer.sv
// Directed bench for phase_lamp_sequencer.
// Expected lamp/index/fault words are queued before each step and popped after.
module tb_phase_lamp_sequencer;

  localparam logic [1:0] GO = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] A  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] O  = 3'b000;

  typedef struct packed {
    logic [11:0] lamps;
    logic [1:0]  idx;
    logic        flt;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] cmd_e, cmd_w, cmd_n, cmd_s;
  logic [2:0] lamp_e, lamp_w, lamp_n, lamp_s;
  logic [1:0] active_idx;
  logic       fault;

  obs_t  q_exp[$];
  string q_tag[$];
  int    n_pass;
  int    n_total;

  phase_lamp_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .cmd_e      (cmd_e),
    .cmd_w      (cmd_w),
    .cmd_n      (cmd_n),
    .cmd_s      (cmd_s),
    .lamp_e     (lamp_e),
    .lamp_w     (lamp_w),
    .lamp_n     (lamp_n),
    .lamp_s     (lamp_s),
    .active_idx (active_idx),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(string t, logic [11:0] l, logic [1:0] i, logic f);
    obs_t e;
    e.lamps = l;
    e.idx   = i;
    e.flt   = f;
    q_exp.push_back(e);
    q_tag.push_back(t);
  endtask

  task automatic pop_chk();
    obs_t e, o;
    string t;
    n_total++;
    if (q_exp.size() == 0) begin
      $error("FAIL sb_empty obs=none exp=entry");
      return;
    end
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    o.lamps = {lamp_e, lamp_w, lamp_n, lamp_s};
    o.idx   = active_idx;
    o.flt   = fault;
    assert (o === e) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", t, o, e);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cstep(string t, logic [11:0] l, logic [1:0] i, logic f);
    push(t, l, i, f);
    cyc(1);
    pop_chk();
  endtask

  task automatic tstep(string t, logic [11:0] l, logic [1:0] i, logic f);
    push(t, l, i, f);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    pop_chk();
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    tick  = 1'b0;
    cmd_e = GO; cmd_w = ST; cmd_n = ST; cmd_s = ST;
    cstep("reset", {R, R, R, R}, 2'd0, 1'b0);
    rst_n = 1'b1;

    tstep("clr_e1", {R, R, R, R}, 2'd0, 1'b0);
    tstep("grn_e", {G, R, R, R}, 2'd0, 1'b0);
    cstep("hold_e", {G, R, R, R}, 2'd0, 1'b0);

    cmd_e = ST; cmd_w = GO;
    for (int k = 0; k < 3; k++) tstep("amb_e", {A, R, R, R}, 2'd0, 1'b0);
    for (int k = 0; k < 2; k++) tstep("red_ew", {R, R, R, R}, 2'd0, 1'b0);
    tstep("grn_w", {R, G, R, R}, 2'd1, 1'b0);

    cmd_w = ST;
    for (int k = 0; k < 3; k++) tstep("amb_w", {R, A, R, R}, 2'd1, 1'b0);
    for (int k = 0; k < 51; k++) tstep("idle_red", {R, R, R, R}, 2'd1, 1'b0);
    cmd_s = GO;
    tstep("grn_s", {R, R, R, G}, 2'd3, 1'b0);

    cmd_e = GO;
    cstep("ill_1clk", {R, R, R, G}, 2'd3, 1'b0);
    cmd_e = ST;
    cstep("ill_clear", {R, R, R, G}, 2'd3, 1'b0);
    cmd_s = ST; cmd_e = GO; cmd_n = GO;
    cstep("ill_edge1", {R, R, R, G}, 2'd3, 1'b0);
    cstep("flt_entry", {A, A, A, A}, 2'd3, 1'b1);
    cmd_e = ST; cmd_n = ST; cmd_s = GO;
    tstep("flash_off", {O, O, O, O}, 2'd3, 1'b1);
    tstep("flash_on", {A, A, A, A}, 2'd3, 1'b1);
    tstep("flash_off2", {O, O, O, O}, 2'd3, 1'b1);

    rst_n = 1'b0;
    #1;
    push("async_rst", {R, R, R, R}, 2'd0, 1'b0);
    pop_chk();
    cyc(1);
    rst_n = 1'b1;
    cmd_s = ST; cmd_e = GO;
    tstep("r2_clr", {R, R, R, R}, 2'd0, 1'b0);
    tstep("r2_grn_e", {G, R, R, R}, 2'd0, 1'b0);
    cmd_e = ST; cmd_n = GO;
    tstep("r2_amb_e", {A, R, R, R}, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push("mid_amb_rst", {R, R, R, R}, 2'd0, 1'b0);
    pop_chk();
    cyc(1);
    rst_n = 1'b1;
    tstep("r3_clr", {R, R, R, R}, 2'd0, 1'b0);
    tstep("r3_grn_n", {R, R, G, R}, 2'd2, 1'b0);

    tick = 1'b1;
    cmd_n = ST; cmd_e = GO;
    for (int k = 0; k < 3; k++) cstep("th_amb_n", {R, R, A, R}, 2'd2, 1'b0);
    for (int k = 0; k < 2; k++) cstep("th_red1", {R, R, R, R}, 2'd2, 1'b0);
    cstep("th_grn_e", {G, R, R, R}, 2'd0, 1'b0);
    cmd_e = ST; cmd_w = GO;
    for (int k = 0; k < 3; k++) cstep("th_amb_e", {A, R, R, R}, 2'd0, 1'b0);
    for (int k = 0; k < 2; k++) cstep("th_red2", {R, R, R, R}, 2'd0, 1'b0);
    cstep("th_grn_w", {R, G, R, R}, 2'd1, 1'b0);
    tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
